// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the inter-stage pipeline registers of the core.
//  - Control/data payload widths for each stage boundary (IF/ID .. MEM/WB).
//  - Bit-field offsets of the control bus so stages agree on the layout.
//  - Slot-occupancy state encoding used by the skid-buffered register.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  // Payload widths per stage boundary
  localparam int IFID_CTRL_W = 1;
  localparam int IFID_DATA_W = 96;   // instr, pc, pcplus4
  localparam int IDEX_CTRL_W = 14;
  localparam int IDEX_DATA_W = 175;  // rd1, rd2, pc, imm, pcplus4, rs1, rs2, rd
  localparam int EXMM_CTRL_W = 9;
  localparam int EXMM_DATA_W = 165;  // aluresult, writedata, pcplus4, pctarget, imm, rd
  localparam int MMWB_CTRL_W = 6;
  localparam int MMWB_DATA_W = 133;  // aluresult, readdata, pcplus4, imm, rd

  // Control bus bit-field layout (LSB first)
  localparam int CTRL_REGWRITE_BIT  = 0;
  localparam int CTRL_RESULTSRC_LSB = 1;
  localparam int CTRL_RESULTSRC_W   = 2;
  localparam int CTRL_LOADSRC_LSB   = 3;
  localparam int CTRL_LOADSRC_W     = 3;
  localparam int CTRL_MEMWRITE_BIT  = 6;
  localparam int CTRL_BRANCH_BIT    = 7;
  localparam int CTRL_JUMP_BIT      = 8;

  // Occupancy of the skid-buffered register: main slot and skid slot
  typedef logic [1:0] slot_state_t;
  localparam slot_state_t ST_EMPTY = 2'd0;  // main empty, skid empty
  localparam slot_state_t ST_ONE   = 2'd1;  // main full,  skid empty
  localparam slot_state_t ST_FULL  = 2'd2;  // main full,  skid full

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_slot
// One storage entry of a pipeline register: valid bit, control payload and
// data payload. Control is zeroed whenever the entry is not valid so that a
// bubble can never assert regwrite/memwrite downstream; data only changes on
// load or reset.
// Ports:
//  clk_i    rising-edge clock
//  rst_i    synchronous active-high reset (clears valid, ctrl and data)
//  load_i   capture ctrl_i/data_i and mark the entry valid
//  clear_i  drop the entry: valid and ctrl go to 0, data holds (beats load_i)
//  ctrl_i   control payload to capture
//  data_i   data payload to capture
//  valid_o  entry holds a payload
//  ctrl_o   stored control payload (0 when not valid)
//  data_o   stored data payload
// ---------------------------------------------------------------------------
module pipe_stage_reg_slot #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 165
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  import pipe_stage_reg_pkg::*;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Clear wins over load so that a flush in the same cycle kills the entry.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register with valid/ready handshake, flush to
// bubble, optional 2-entry skid buffer and a saturating stall-cycle counter.
// SKID=0: one slot, in_ready combinational from out_ready.
// SKID=1: main + skid slot, in_ready depends only on registered state.
// Ports:
//  clk_i        rising-edge clock
//  rst_i        synchronous active-high reset
//  in_valid_i   upstream payload valid
//  in_ready_o   payload accepted this cycle when in_valid_i is also high
//  in_ctrl_i    upstream control payload
//  in_data_i    upstream data payload
//  flush_i      kill held and incoming payload this cycle
//  out_valid_o  output payload valid
//  out_ready_i  downstream accepts the output payload
//  out_ctrl_o   output control (0 whenever out_valid_o is 0)
//  out_data_o   output data
//  stall_cnt_o  saturating count of cycles with out_valid_o & ~out_ready_i
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 165,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  import pipe_stage_reg_pkg::*;

  logic              inReady;
  logic              xfer;
  logic              pop;
  logic              mainValid;
  logic              mainLoad;
  logic              mainClear;
  logic [CTRL_W-1:0] mainCtrlIn;
  logic [DATA_W-1:0] mainDataIn;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

  // A flush masks the transfer even when in_ready is high.
  assign pop  = mainValid & out_ready_i;
  assign xfer = in_valid_i & inReady & ~flush_i;

  pipe_stage_reg_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) uMainSlot (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (mainLoad),
    .clear_i(mainClear),
    .ctrl_i (mainCtrlIn),
    .data_i (mainDataIn),
    .valid_o(mainValid),
    .ctrl_o (mainCtrl),
    .data_o (mainData)
  );

  generate
    if (SKID == 0) begin : gSingle
      // Single slot: room whenever empty or being drained this cycle.
      assign inReady    = ~rst_i & (~mainValid | out_ready_i);
      assign mainLoad   = xfer;
      assign mainClear  = flush_i | (pop & ~xfer);
      assign mainCtrlIn = in_ctrl_i;
      assign mainDataIn = in_data_i;
    end else begin : gSkid
      slot_state_t       state_q, state_d;
      logic              skidValid;
      logic              skidLoad;
      logic              skidClear;
      logic              mainFromSkid;
      logic [CTRL_W-1:0] skidCtrl;
      logic [DATA_W-1:0] skidData;

      pipe_stage_reg_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) uSkidSlot (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (skidLoad),
        .clear_i(skidClear),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .valid_o(skidValid),
        .ctrl_o (skidCtrl),
        .data_o (skidData)
      );

      // Ready only looks at the skid entry, so there is no path from
      // out_ready back to in_ready.
      assign inReady    = ~rst_i & ~skidValid;
      assign mainCtrlIn = mainFromSkid ? skidCtrl : in_ctrl_i;
      assign mainDataIn = mainFromSkid ? skidData : in_data_i;

      // Occupancy FSM. The main slot always holds the oldest payload; the
      // skid slot only fills when a beat arrives while main is stuck.
      always_comb begin
        state_d      = state_q;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        mainFromSkid = 1'b0;
        if (flush_i) begin
          mainClear = 1'b1;
          skidClear = 1'b1;
          state_d   = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (xfer) begin
                mainLoad = 1'b1;
                state_d  = ST_ONE;
              end
            end
            ST_ONE: begin
              if (xfer && pop) begin
                mainLoad = 1'b1;
              end else if (xfer) begin
                skidLoad = 1'b1;
                state_d  = ST_FULL;
              end else if (pop) begin
                mainClear = 1'b1;
                state_d   = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (pop) begin
                mainLoad     = 1'b1;
                mainFromSkid = 1'b1;
                skidClear    = 1'b1;
                state_d      = ST_ONE;
              end
            end
            default: begin
              mainClear = 1'b1;
              skidClear = 1'b1;
              state_d   = ST_EMPTY;
            end
          endcase
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q <= ST_EMPTY;
        end else begin
          state_q <= state_d;
        end
      end
    end
  endgenerate

  // Stall counter sticks at all-ones instead of wrapping; flush leaves it alone.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (mainValid && !out_ready_i && !(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign in_ready_o  = inReady;
  assign out_valid_o = mainValid;
  assign out_ctrl_o  = mainCtrl;
  assign out_data_o  = mainData;
  assign stall_cnt_o = stallCnt_q;

endmodule
